// File: rtl/imem_fetch_unit.sv
// ---------------------------------------------------------------------------
// imem_fetch_unit
//
// Byte-wide instruction memory with a clear/load/run life cycle.
//   CLEAR : a counter zeroes every byte, one per cycle (DEPTH cycles).
//   LOAD  : program image is streamed in through a valid/ready byte port.
//   RUN   : fetches return FETCH_BYTES consecutive bytes starting at f_pc,
//           one cycle after acceptance. reload returns to CLEAR.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   ld_valid/ready  : program-load handshake
//   ld_addr/ld_data : byte address / byte value of a load beat
//   ld_last         : final beat of the image (moves to RUN)
//   ld_err          : one-cycle pulse, accepted beat was out of range
//   reload          : in RUN, clear memory and wait for a new image
//   f_req/f_ready   : fetch handshake
//   f_pc            : fetch byte address
//   f_valid         : one-cycle response strobe
//   f_byte0         : mem[f_pc]
//   f_bytes         : mem[f_pc+1] (MSB byte) .. mem[f_pc+FETCH_BYTES-1] (LSB)
//   f_err           : fetch window ran past the end of memory
//   state           : 0=CLEAR, 1=LOAD, 2=RUN
// ---------------------------------------------------------------------------
module imem_fetch_unit #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 64,
   parameter int FETCH_BYTES = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ld_valid,
   output logic                         ld_ready,
   input  logic [ADDR_W-1:0]            ld_addr,
   input  logic [7:0]                   ld_data,
   input  logic                         ld_last,
   output logic                         ld_err,
   input  logic                         reload,
   input  logic                         f_req,
   output logic                         f_ready,
   input  logic [ADDR_W-1:0]            f_pc,
   output logic                         f_valid,
   output logic [7:0]                   f_byte0,
   output logic [8*(FETCH_BYTES-1)-1:0] f_bytes,
   output logic                         f_err,
   output logic [1:0]                   state
);

   localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = 8 * (FETCH_BYTES - 1);

   // Constants for the out-of-range checks. The fetch comparison is done one
   // bit wider than the PC so that a PC near the top of the address space
   // cannot wrap its last byte back into range.
   localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LAST_OFS  = (ADDR_W+1)'(FETCH_BYTES - 1);
   localparam logic [MW-1:0]     CLR_LAST  = MW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t          state_reg;
   logic [MW-1:0]   clr_cnt_reg;
   logic            ld_ready_reg;
   logic            f_ready_reg;
   logic            ld_err_reg;
   logic            f_valid_reg;
   logic            f_err_reg;
   logic [7:0]      f_byte0_reg;
   logic [BW-1:0]   f_bytes_reg;

   // Byte storage. No reset: contents are defined only after CLEAR runs.
   logic [7:0]      mem [DEPTH];

   // ------------------------------------------------------------------
   // Handshakes and range checks
   // ------------------------------------------------------------------
   logic            ld_accept;
   logic            ld_in_range;
   logic            f_accept;
   logic [ADDR_W:0] f_end;
   logic            f_oob;

   assign ld_accept   = ld_valid && ld_ready_reg;
   assign ld_in_range = (ld_addr < DEPTH_A);
   assign f_accept    = f_req && f_ready_reg;
   assign f_end       = {1'b0, f_pc} + LAST_OFS;
   assign f_oob       = (f_end >= DEPTH_X);

   // ------------------------------------------------------------------
   // Single write port, shared by the clear counter and the load port.
   // The two sources are mutually exclusive by state.
   // ------------------------------------------------------------------
   logic            mem_we;
   logic [MW-1:0]   mem_waddr;
   logic [7:0]      mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = 8'h00;
      if (state_reg == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_reg;
      end else if ((state_reg == ST_LOAD) && ld_accept && ld_in_range) begin
         mem_we    = 1'b1;
         mem_waddr = ld_addr[MW-1:0];
         mem_wdata = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Fetch window read. Indices are taken modulo the memory size; when the
   // window would run past the end the result is discarded (f_oob), so the
   // truncation never leaks wrapped data.
   // ------------------------------------------------------------------
   logic [MW-1:0]   f_idx;
   logic [7:0]      rd_byte0;
   logic [BW-1:0]   rd_bytes;

   assign f_idx    = f_pc[MW-1:0];
   assign rd_byte0 = mem[f_idx];

   generate
      for (genvar gi = 1; gi < FETCH_BYTES; gi++) begin : g_rd
         // Byte PC+gi lands with PC+1 in the top byte lane.
         assign rd_bytes[8*(FETCH_BYTES-1-gi) +: 8] = mem[f_idx + MW'(gi)];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_CLEAR;
         clr_cnt_reg  <= '0;
         ld_ready_reg <= 1'b0;
         f_ready_reg  <= 1'b0;
         ld_err_reg   <= 1'b0;
         f_valid_reg  <= 1'b0;
         f_err_reg    <= 1'b0;
         f_byte0_reg  <= 8'h00;
         f_bytes_reg  <= '0;
      end else begin
         ld_err_reg  <= 1'b0;
         f_valid_reg <= 1'b0;

         case (state_reg)
            ST_CLEAR: begin
               if (clr_cnt_reg == CLR_LAST) begin
                  state_reg    <= ST_LOAD;
                  ld_ready_reg <= 1'b1;
               end else begin
                  clr_cnt_reg <= clr_cnt_reg + 1'b1;
               end
            end

            ST_LOAD: begin
               if (ld_accept) begin
                  ld_err_reg <= !ld_in_range;
                  if (ld_last) begin
                     state_reg    <= ST_RUN;
                     ld_ready_reg <= 1'b0;
                     f_ready_reg  <= 1'b1;
                  end
               end
            end

            ST_RUN: begin
               if (reload) begin
                  state_reg   <= ST_CLEAR;
                  clr_cnt_reg <= '0;
                  f_ready_reg <= 1'b0;
               end
            end

            default: begin
               state_reg    <= ST_CLEAR;
               clr_cnt_reg  <= '0;
               ld_ready_reg <= 1'b0;
               f_ready_reg  <= 1'b0;
            end
         endcase

         // A fetch accepted alongside reload still completes: the read
         // above samples memory before the first clear write lands.
         if (f_accept) begin
            f_valid_reg <= 1'b1;
            f_err_reg   <= f_oob;
            f_byte0_reg <= f_oob ? 8'h00 : rd_byte0;
            f_bytes_reg <= f_oob ? '0 : rd_bytes;
         end
      end
   end

   assign ld_ready = ld_ready_reg;
   assign f_ready  = f_ready_reg;
   assign ld_err   = ld_err_reg;
   assign f_valid  = f_valid_reg;
   assign f_err    = f_err_reg;
   assign f_byte0  = f_byte0_reg;
   assign f_bytes  = f_bytes_reg;
   assign state    = state_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_unit
//
// Directed bench for imem_fetch_unit at DEPTH=64, FETCH_BYTES=10.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// at that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_imem_fetch_unit;

   localparam int DEPTH       = 64;
   localparam int ADDR_W      = 64;
   localparam int FETCH_BYTES = 10;
   localparam int BW          = 8 * (FETCH_BYTES - 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ld_valid = 1'b0;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [7:0]        ld_data = 8'h00;
   logic              ld_last = 1'b0;
   logic              ld_err;
   logic              reload = 1'b0;
   logic              f_req = 1'b0;
   logic              f_ready;
   logic [ADDR_W-1:0] f_pc = '0;
   logic              f_valid;
   logic [7:0]        f_byte0;
   logic [BW-1:0]     f_bytes;
   logic              f_err;
   logic [1:0]        state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imem_fetch_unit #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .FETCH_BYTES(FETCH_BYTES)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_valid(ld_valid),
      .ld_ready(ld_ready),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .ld_last (ld_last),
      .ld_err  (ld_err),
      .reload  (reload),
      .f_req   (f_req),
      .f_ready (f_ready),
      .f_pc    (f_pc),
      .f_valid (f_valid),
      .f_byte0 (f_byte0),
      .f_bytes (f_bytes),
      .f_err   (f_err),
      .state   (state)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) begin
         $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
      end else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_beat(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic last);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] pc);
      f_req = 1'b1;
      f_pc  = pc;
      tick();
      f_req = 1'b0;
   endtask

   task automatic chk_resp(input string tag, input logic [7:0] b0, input logic [BW-1:0] bs,
                           input logic er);
      chk({tag, "_valid"}, f_valid, 1'b1);
      chk({tag, "_byte0"}, f_byte0, b0);
      chk({tag, "_bytes"}, f_bytes, bs);
      chk({tag, "_err"},   f_err,   er);
   endtask

   initial begin
      // ---------------- reset state ----------------
      ticks(2);
      chk("rst_state",   state,   2'd0);
      chk("rst_ldready", ld_ready, 1'b0);
      chk("rst_fready",  f_ready, 1'b0);
      chk("rst_fvalid",  f_valid, 1'b0);
      chk("rst_lderr",   ld_err,  1'b0);
      chk("rst_ferr",    f_err,   1'b0);
      chk("rst_byte0",   f_byte0, 8'h00);
      chk("rst_bytes",   f_bytes, '0);

      // ---------------- clear lasts exactly 64 cycles ----------------
      rst_n = 1'b1;
      ticks(63);
      chk("clr63_ldready", ld_ready, 1'b0);
      chk("clr63_state",   state,    2'd0);
      tick();
      chk("clr64_ldready", ld_ready, 1'b1);
      chk("clr64_state",   state,    2'd1);
      chk("load_fready",   f_ready,  1'b0);

      // ---------------- only ld_last at 63 -> all zero memory ----------------
      load_beat(64'd63, 8'h00, 1'b1);
      chk("a_state_run", state,    2'd2);
      chk("a_fready",    f_ready,  1'b1);
      chk("a_ldready",   ld_ready, 1'b0);
      fetch(64'd0);
      chk_resp("a_pc0", 8'h00, '0, 1'b0);
      fetch(64'd54);
      chk_resp("a_pc54", 8'h00, '0, 1'b0);

      // ---------------- reload -> clear for 64 cycles ----------------
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("rl_state",  state,   2'd0);
      chk("rl_fready", f_ready, 1'b0);
      ticks(63);
      chk("rl63_state", state, 2'd0);
      tick();
      chk("rl64_state", state, 2'd1);

      // ---------------- load image with out-of-range beats ----------------
      load_beat(64'd0, 8'h30, 1'b0);
      chk("b_lderr_inrange", ld_err, 1'b0);
      load_beat(64'd64, 8'hEE, 1'b0);
      chk("b_lderr64", ld_err, 1'b1);
      chk("b_fready_oor", f_ready, 1'b0);
      tick();
      chk("b_lderr_drop", ld_err, 1'b0);
      load_beat(64'd76, 8'hEE, 1'b0);
      chk("b_lderr76", ld_err, 1'b1);
      load_beat(64'd1, 8'hF0, 1'b0);
      load_beat(64'd2, 8'h05, 1'b0);
      for (int a = 3; a < 9; a++) load_beat(64'(a), 8'h00, 1'b0);
      // reload is ignored in LOAD
      reload = 1'b1;
      tick();
      reload = 1'b0;
      chk("b_reload_ign", state, 2'd1);
      chk("b_fready_pre", f_ready, 1'b0);
      load_beat(64'd9, 8'h00, 1'b1);
      chk("b_state_run", state, 2'd2);

      // ---------------- fetches ----------------
      fetch(64'd0);
      chk_resp("f_pc0", 8'h30, 72'hF0_05_00_00_00_00_00_00_00, 1'b0);
      tick();
      chk("hold_valid", f_valid, 1'b0);
      chk("hold_byte0", f_byte0, 8'h30);
      chk("hold_bytes", f_bytes, 72'hF0_05_00_00_00_00_00_00_00);
      fetch(64'd12);
      chk_resp("f_pc12_nowrap", 8'h00, '0, 1'b0);
      fetch(64'd54);
      chk_resp("f_pc54", 8'h00, '0, 1'b0);
      fetch(64'd55);
      chk_resp("f_pc55", 8'h00, '0, 1'b1);
      fetch(64'hFFFF_FFFF_FFFF_FFFE);
      chk_resp("f_pcwrap", 8'h00, '0, 1'b1);

      // ---------------- back-to-back with reload ----------------
      f_req = 1'b1;
      f_pc  = 64'd0;
      tick();
      chk_resp("bb_pc0", 8'h30, 72'hF0_05_00_00_00_00_00_00_00, 1'b0);
      f_pc = 64'd1;
      tick();
      chk_resp("bb_pc1", 8'hF0, 72'h05_00_00_00_00_00_00_00_00, 1'b0);
      f_pc   = 64'd2;
      reload = 1'b1;
      tick();
      f_req  = 1'b0;
      reload = 1'b0;
      chk_resp("bb_pc2", 8'h05, '0, 1'b0);
      chk("bb_state",  state,   2'd0);
      chk("bb_fready", f_ready, 1'b0);
      tick();
      chk("bb_nopulse", f_valid, 1'b0);
      ticks(62);
      chk("bb63_state",  state,   2'd0);
      chk("bb63_fready", f_ready, 1'b0);
      tick();
      chk("bb64_state", state, 2'd1);

      // ---------------- asynchronous reset during LOAD ----------------
      load_beat(64'd70, 8'h11, 1'b0);
      chk("ar_lderr_pre", ld_err,  1'b1);
      chk("ar_byte0_pre", f_byte0, 8'h05);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_state",   state,    2'd0);
      chk("ar_ldready", ld_ready, 1'b0);
      chk("ar_lderr",   ld_err,   1'b0);
      chk("ar_byte0",   f_byte0,  8'h00);
      ticks(2);
      #2 rst_n = 1'b1;
      ticks(63);
      chk("ar63_state", state, 2'd0);
      chk("ar63_lderr", ld_err, 1'b0);
      tick();
      chk("ar64_state", state, 2'd1);

      // memory must be zero again after the repeated clear
      load_beat(64'd63, 8'h00, 1'b1);
      fetch(64'd0);
      chk_resp("ar_pc0", 8'h00, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_fetch_unit.md
IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
 DEPTH  1024  memory size in bytes.
 ADDR_W  64  width of address/PC ports.
 FETCH_BYTES  10  bytes returned per fetch, PC+0 .. PC+FETCH_BYTES-1.
REQ-002 Ports, one per line: name  direction  width  meaning.
 clk  in  1  the single clock; all state updates on its rising edge.
 rst_n  in  1  asynchronous, active-low reset.
 ld_valid  in  1  program-load beat offered.
 ld_ready  out  1  load beat can be accepted.
 ld_addr  in  ADDR_W  byte address of load beat.
 ld_data  in  8  byte to write.
 ld_last  in  1  final beat of program image.
 ld_err  out  1  one-cycle pulse: accepted beat was out of range.
 reload  in  1  request to clear the memory and reload it.
 f_req  in  1  fetch request.
 f_ready  out  1  fetch can be accepted.
 f_pc  in  ADDR_W  fetch address.
 f_valid  out  1  fetch response valid, one-cycle pulse.
 f_byte0  out  8  mem[f_pc], the instruction byte.
 f_bytes  out  8*(FETCH_BYTES-1)  mem[f_pc+1] in the MSB byte down to mem[f_pc+FETCH_BYTES-1] in the LSB byte.
 f_err  out  1  fetch out of range; qualified by f_valid.
 state  out  2  0=CLEAR, 1=LOAD, 2=RUN.

Function
REQ-003 The state machine has exactly three states: CLEAR, LOAD, RUN.
REQ-004 In CLEAR, a counter writes 0x00 to byte 0 through byte DEPTH-1, one byte per cycle.
REQ-005 In CLEAR, ld_ready=0 and f_ready=0.
REQ-006 After writing byte DEPTH-1, the block moves to LOAD on the next edge, so CLEAR lasts exactly DEPTH cycles.
REQ-007 In LOAD: ld_ready=1, f_ready=0.
REQ-008 A beat is accepted when ld_valid and ld_ready are both 1 at a rising edge.
REQ-009 An accepted beat with ld_addr < DEPTH writes ld_data to mem[ld_addr].
REQ-010 An accepted beat with ld_addr >= DEPTH writes nothing and pulses ld_err in the following cycle.
REQ-011 An accepted beat with ld_last=1 is written (if in range), then the block moves to RUN.
REQ-012 In RUN: ld_ready=0, f_ready=1; ld_valid is ignored.
REQ-013 A fetch is accepted when f_req and f_ready are both 1 at a rising edge; one fetch may be accepted every cycle.
REQ-014 Read latency is exactly one cycle: f_valid=1 in the cycle after acceptance; outputs are registered.
REQ-015 f_err=1 when f_pc+FETCH_BYTES-1 >= DEPTH.
REQ-016 The f_err comparison is evaluated at ADDR_W+1 bits so that PC wrap-around can never produce an in-range result.
REQ-017 When f_err=1, f_byte0=0 and f_bytes=0.
REQ-018 When f_valid=0, f_byte0, f_bytes and f_err hold their last values.
REQ-019 reload=1 in RUN moves the block to CLEAR on the next edge and restarts the clear counter at 0.
REQ-020 A fetch accepted in the same cycle as reload still returns its f_valid response in the following cycle, with data read before the clear begins.
REQ-021 reload is ignored in CLEAR and LOAD.
REQ-022 Out-of-range addressing never writes memory and never wraps to a low address.

Reset
REQ-023 rst_n=0 asynchronously forces: state=CLEAR, clear counter=0, ld_ready=0, f_ready=0, f_valid=0, ld_err=0, f_err=0, f_byte0=0, f_bytes=0.
REQ-024 Reset mid-load or mid-fetch discards all in-flight work; no f_valid and no ld_err pulse is produced for it.
REQ-025 Memory contents are undefined during reset and are all-zero once CLEAR completes.
REQ-026 The first clear write occurs on the first rising edge with rst_n=1.

Verification (DEPTH=64, FETCH_BYTES=10)
REQ-027 Release rst_n -> ld_ready=1 exactly 64 cycles later; a fetch issued after loading only ld_last at address 63 returns all-zero bytes at any in-range PC.
REQ-028 Load 30 F0 05 00 00 00 00 00 00 00 at addresses 0-9 with ld_last on the address-9 beat, then fetch PC=0 -> next cycle f_valid=1, f_byte0=0x30, f_bytes=0xF0_05_00_00_00_00_00_00_00, f_err=0.
REQ-029 Fetch PC=54 -> f_err=0; fetch PC=55 -> f_err=1 with zero data; fetch PC=2^64-2 -> f_err=1.
REQ-030 Load beat at ld_addr=64 -> ld_err pulses for 1 cycle and memory is unchanged; f_ready stays 0 until the ld_last beat is accepted.
REQ-031 Back-to-back fetches PC=0,1,2 with reload asserted alongside PC=2 -> three f_valid pulses carrying the pre-clear data, then state=CLEAR and f_ready=0 for 64 cycles.
REQ-032 Assert rst_n=0 between clock edges during LOAD -> outputs zero immediately with no edge; after release, the full 64-cycle clear repeats.
